// File: rtl/acc_rec_pkg.sv
// Shared types and helpers for the accumulator vector recorder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_rec_pkg;

    localparam int D_W   = 4;
    localparam int Q_W   = 4;
    localparam int VEC_W = D_W + 1 + Q_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One observation packed as {d, a_clk, q}, with d in the top bits.
    function automatic logic [VEC_W-1:0] pack_vec(
        input logic [D_W-1:0] d,
        input logic           a_clk,
        input logic [Q_W-1:0] q
    );
        return {d, a_clk, q};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; reads as zero when empty.
// Latency: an entry written at edge N is visible on pop_dat at cycle N+1.
// Backpressure: a push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching the storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/acc_vec_recorder.sv
// Records {d, a_clk, q} every cycle of a run into a FIFO for a downstream reader.
// Latency: a sample taken at edge N into an empty FIFO is on out_vec at cycle N+1.
// Backpressure: out_valid/out_ready; a sample arriving with the FIFO full and no pop is dropped and flagged.
module acc_vec_recorder
    import acc_rec_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_VEC = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [D_W-1:0]   d,
    input  logic             a_clk,
    input  logic [Q_W-1:0]   q,
    output logic [VEC_W-1:0] out_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count,
    output logic             overflow
);

    state_t state;
    state_t state_nxt;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic at_max;
    logic capture;
    logic push_ok;
    logic drop;
    logic enter_record;

    assign at_max       = (vec_count == 32'(MAX_VEC));
    assign capture      = (state == RECORD) && !at_max;
    assign fifo_pop     = out_valid && out_ready;
    assign push_ok      = capture && (!fifo_full || fifo_pop);
    assign drop         = capture && fifo_full && !fifo_pop;
    assign enter_record = ((state == IDLE) || (state == DONE)) && start;

    assign out_valid = !fifo_empty;
    assign busy      = (state == RECORD) || (state == DRAIN);
    assign done      = (state == DONE);

    sync_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_ok),
        .push_dat (pack_vec(d, a_clk, q)),
        .pop      (fifo_pop),
        .pop_dat  (out_vec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: start wins over stop when idle or done; the stop-edge sample is still captured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)          state_nxt = RECORD;
            RECORD:     if (stop || at_max) state_nxt = DRAIN;
            DRAIN:      if (fifo_empty)     state_nxt = DONE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Accepted-vector counter, cleared on run entry; at_max gating makes it saturate.
    always_ff @(posedge clk) begin
        if (!rst)              vec_count <= '0;
        else if (enter_record) vec_count <= '0;
        else if (push_ok)      vec_count <= vec_count + 32'd1;
    end

    // Sticky drop flag for the current run.
    always_ff @(posedge clk) begin
        if (!rst)              overflow <= 1'b0;
        else if (enter_record) overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
    end

endmodule

// File: tb/tb_acc_vec_recorder.sv
// Randomized scoreboard bench for acc_vec_recorder against a queue-level model.
// Latency: n/a.
// Backpressure: out_ready driven both fixed and random.
module tb_acc_vec_recorder;

    localparam int DEPTH = 16;
    localparam int MAXV  = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [3:0]  d;
    logic        a_clk;
    logic [3:0]  q;
    logic [8:0]  out_vec;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [31:0] vec_count;
    logic        overflow;

    acc_vec_recorder #(.DEPTH(DEPTH), .MAX_VEC(MAXV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .d         (d),
        .a_clk     (a_clk),
        .q         (q),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: a run records one sample per cycle after start, keeps the
    // stop-cycle sample, caps at MAXV samples, and can only hold DEPTH vectors.
    logic [8:0] exp_q[$];
    int  occ    = 0;
    int  m_cnt  = 0;
    bit  m_run  = 0;
    bit  m_drn  = 0;
    bit  m_fin  = 0;
    bit  m_ovf  = 0;
    bit  m_rst  = 1;
    bit  mon_en = 0;
    bit  m_pop;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            occ = 0; m_cnt = 0; m_run = 0; m_drn = 0; m_fin = 0; m_ovf = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            m_pop = out_ready && (occ > 0);
            if (m_run) begin
                if (m_cnt < MAXV) begin
                    if (occ < DEPTH || m_pop) begin
                        exp_q.push_back({d, a_clk, q});
                        occ++;
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                    if (stop) begin m_run = 0; m_drn = 1; end
                end else begin
                    m_run = 0; m_drn = 1;
                end
            end else if (m_drn) begin
                if (occ == 0) begin m_drn = 0; m_fin = 1; end
            end else if (start) begin
                m_run = 1; m_cnt = 0; m_ovf = 0; m_fin = 0;
            end
            if (m_pop) occ--;
        end
    end

    // Monitor: compares status every cycle and the head vector whenever one is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, (occ > 0));
            chk("busy", busy, m_run || m_drn);
            chk("done", done, m_fin);
            chk("vec_count", vec_count, m_cnt);
            chk("overflow", overflow, m_ovf);
            if (m_rst) chk("reset_out_vec", out_vec, 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("out_vec", out_vec, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_data();
        d     = 4'($urandom);
        a_clk = 1'($urandom);
        q     = 4'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1; rnd_data(); cyc(); start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !m_fin; i++) begin
            rnd_data();
            cyc();
        end
        if (!m_fin) fail_now("wait_done");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        d = '0; a_clk = 1'b0; q = '0;
        cyc();
        mon_en = 1;
        cyc();
        rst = 1'b1;

        // Basic run: three fixed vectors, stop on the third capture cycle.
        out_ready = 1'b1;
        pulse_start();
        d = 4'b0011; a_clk = 1'b1; q = 4'b0101;
        cyc(); cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("basic_count", vec_count, 3);
        wait_done();

        // Backpressure: 20 samples into a 16-deep FIFO with no reader.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 19; i++) begin rnd_data(); cyc(); end
        stop = 1'b1; rnd_data(); cyc(); stop = 1'b0;
        chk("bp_count", vec_count, 16);
        chk("bp_overflow", overflow, 1);
        repeat (3) cyc();
        out_ready = 1'b1;
        wait_done();

        // Full FIFO with simultaneous push/pop, then auto-stop at MAXV.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin rnd_data(); cyc(); end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (m_run); i++) begin rnd_data(); cyc(); end
        chk("auto_count", vec_count, MAXV);
        chk("full_overflow", overflow, 0);
        wait_done();

        // start and stop together in DONE: start wins.
        start = 1'b1; stop = 1'b1; rnd_data(); cyc();
        start = 1'b0; stop = 1'b0; rnd_data(); cyc();
        chk("ss_busy", busy, 1);
        chk("ss_count", vec_count, 1);
        for (int i = 0; i < 4; i++) begin rnd_data(); cyc(); end
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_done();

        // Random control and backpressure, including ignored start/stop pulses.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 14) == 0);
            rnd_data();
            cyc();
        end
        start = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // Reset in the middle of a run with seven buffered vectors.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin rnd_data(); cyc(); end
        chk("pre_rst_count", vec_count, 7);
        rst = 1'b0; cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", vec_count, 0);
        chk("rst_vec", out_vec, 0);
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_vec_recorder.md
ACC_VEC_RECORDER -- requirements
Module: acc_vec_recorder

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries, power of two, >= 2.
REQ-002 Parameter MAX_VEC, default 10000: vectors recorded per run before automatic stop.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a recording run.
REQ-006 stop  in  1  one-cycle pulse; ends the current run.
REQ-007 d  in  4  accumulator data input being observed.
REQ-008 a_clk  in  1  accumulator clock level being observed.
REQ-009 q  in  4  accumulator output being observed.
REQ-010 out_vec  out  9  head vector, packed {d, a_clk, q}; d in bits 8:5, a_clk in bit 4, q in bits 3:0.
REQ-011 out_valid  out  1  out_vec holds an unread vector.
REQ-012 out_ready  in  1  consumer accepts out_vec.
REQ-013 busy  out  1  high in RECORD and DRAIN.
REQ-014 done  out  1  high in DONE.
REQ-015 vec_count  out  32  vectors accepted into the FIFO in the current run.
REQ-016 overflow  out  1  sticky: at least one sample was dropped in the current run.

Function
REQ-017 States SHALL be IDLE, RECORD, DRAIN and DONE.
REQ-018 Transitions: start moves IDLE or DONE to RECORD; stop, or vec_count reaching MAX_VEC, moves RECORD to DRAIN; DRAIN moves to DONE when the FIFO is empty; no other transitions exist.
REQ-019 Entering RECORD SHALL clear vec_count and overflow in the same edge.
REQ-020 The FIFO SHALL not be cleared on entering RECORD, so any vectors left from the previous run remain readable.
REQ-021 In RECORD, each cycle SHALL sample {d, a_clk, q} at posedge and push it, starting on the first cycle after start.
REQ-022 The sample taken on the edge that stop is seen SHALL be recorded.
REQ-023 A push SHALL increment vec_count by 1.
REQ-024 A push SHALL be refused when the FIFO is full with no pop in the same cycle; the sample is dropped, overflow is set, and vec_count is unchanged.
REQ-025 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-026 A pop SHALL occur when out_valid and out_ready are both high; out_valid = FIFO not empty.
REQ-027 out_vec and out_valid SHALL be stable while out_valid is high and out_ready is low.
REQ-028 Latency: a vector pushed into an empty FIFO at edge N SHALL appear on out_vec at cycle N+1.
REQ-029 When vec_count reaches MAX_VEC, capture SHALL stop on the following edge, and exactly MAX_VEC vectors are pushed in that run.
REQ-030 start while busy SHALL be ignored.
REQ-031 stop outside RECORD SHALL be ignored.
REQ-032 When start and stop occur together in IDLE or DONE, start SHALL take effect and stop SHALL be ignored.
REQ-033 Pops SHALL remain permitted in every state.
REQ-034 vec_count SHALL saturate at MAX_VEC and never wrap.

Reset
REQ-035 With rst low at posedge, the state SHALL be IDLE, the FIFO empty, and out_valid, busy, done, overflow = 0, vec_count = 0, out_vec = 0.
REQ-036 Reset mid-run SHALL discard all buffered vectors, with no drain.

Structure
REQ-037 Package acc_rec_pkg SHALL hold the state enum, VEC_W = 9, the field widths (D_W = 4, Q_W = 4) and the packing-order function.
REQ-038 Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty) SHALL hold storage.
REQ-039 acc_vec_recorder SHALL hold the FSM, the counter and the overflow logic.

Verification
REQ-040 Basic run: out_ready = 1, start, then d = 4'b0011, a_clk = 1, q = 4'b0101 for 3 cycles, then stop -> three vectors 9'b0011_1_0101, vec_count = 3, done one cycle after the last pop.
REQ-041 Backpressure: DEPTH = 16, out_ready = 0, record 20 cycles -> vec_count = 16, overflow = 1; then out_ready = 1 -> exactly 16 vectors in push order.
REQ-042 Full push/pop: FIFO full, out_ready = 1 in RECORD -> push accepted each cycle, overflow stays 0.
REQ-043 Auto-stop: MAX_VEC = 5 -> exactly 5 vectors, DRAIN to DONE with no stop pulse.
REQ-044 Reset mid-RECORD with 7 buffered -> next cycle out_valid = 0, state IDLE, vec_count = 0.
REQ-045 start + stop together in DONE -> RECORD entered, vec_count cleared, capture continues.
